// File: rtl/button_conditioner_pkg.sv
// Shared types and default timing for the push-button front-end.
// Board builds use the *_BOARD values; simulation uses the shortened *_SIM values.
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        S_LOW      = 2'b00,
        S_RISE_CHK = 2'b01,
        S_HIGH     = 2'b10,
        S_FALL_CHK = 2'b11
    } btn_state_e;

    localparam int unsigned DEB_CYCLES_BOARD  = 250000;
    localparam int unsigned LONG_CYCLES_BOARD = 50000000;
    localparam int unsigned DEB_CYCLES_SIM    = 4;
    localparam int unsigned LONG_CYCLES_SIM   = 20;

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// One button channel: two-flop synchroniser, debounce FSM with hold counter,
// and a registered output stage for the clean level and its pulses.
module debounce_channel
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEB_CYCLES  = DEB_CYCLES_BOARD,
    parameter int unsigned LONG_CYCLES = LONG_CYCLES_BOARD
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic long_o
);

    localparam int unsigned DEB_W  = $clog2(DEB_CYCLES);
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LONG = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

    logic [1:0]        sync_q;
    logic              s;
    btn_state_e        state_q, state_d;
    logic [DEB_W-1:0]  deb_q, deb_d;
    logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
    logic              evt_rise_q, evt_rise_d;
    logic              evt_fall_q, evt_fall_d;
    logic              evt_long_q, evt_long_d;
    logic              out_level_q, out_rise_q, out_fall_q, out_long_q;

    assign s = sync_q[1];

    always_comb begin
        state_d    = state_q;
        deb_d      = deb_q;
        hold_d     = hold_q;
        evt_rise_d = 1'b0;
        evt_fall_d = 1'b0;
        evt_long_d = 1'b0;
        hold_inc   = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;

        case (state_q)
            S_LOW: begin
                if (s) begin
                    state_d = S_RISE_CHK;
                    deb_d   = DEB_W'(1);
                end
            end
            S_RISE_CHK: begin
                if (!s) begin
                    state_d = S_LOW;
                    deb_d   = '0;
                end else if (deb_q == DEB_LAST) begin
                    state_d    = S_HIGH;
                    deb_d      = '0;
                    hold_d     = '0;
                    evt_rise_d = 1'b1;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            S_HIGH: begin
                if (!s) begin
                    state_d = S_FALL_CHK;
                    deb_d   = DEB_W'(1);
                end else begin
                    // Saturation stops hold_inc at LONG_CYCLES, so this matches once per press.
                    hold_d     = hold_inc;
                    evt_long_d = (hold_inc == HOLD_LONG) && (hold_q != HOLD_MAX);
                end
            end
            S_FALL_CHK: begin
                if (s) begin
                    state_d = S_HIGH;
                    deb_d   = '0;
                end else if (deb_q == DEB_LAST) begin
                    state_d    = S_LOW;
                    deb_d      = '0;
                    evt_fall_d = 1'b1;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            default: begin
                state_d = S_LOW;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q      <= '0;
            state_q     <= S_LOW;
            deb_q       <= '0;
            hold_q      <= '0;
            evt_rise_q  <= 1'b0;
            evt_fall_q  <= 1'b0;
            evt_long_q  <= 1'b0;
            out_level_q <= 1'b0;
            out_rise_q  <= 1'b0;
            out_fall_q  <= 1'b0;
            out_long_q  <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], pin_i};
            state_q     <= state_d;
            deb_q       <= deb_d;
            hold_q      <= hold_d;
            evt_rise_q  <= evt_rise_d;
            evt_fall_q  <= evt_fall_d;
            evt_long_q  <= evt_long_d;
            // Output stage trails the FSM by one edge, so level and pulses land together.
            out_level_q <= (state_q == S_HIGH) || (state_q == S_FALL_CHK);
            out_rise_q  <= evt_rise_q;
            out_fall_q  <= evt_fall_q;
            out_long_q  <= evt_long_q;
        end
    end

    assign level_o = out_level_q;
    assign rise_o  = out_rise_q;
    assign fall_o  = out_fall_q;
    assign long_o  = out_long_q;

endmodule

// File: rtl/button_conditioner.sv
// Push-button front-end: N_BTN independent debounce channels producing clean
// levels plus one-cycle rise, fall and long-press pulses in the clk domain.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned N_BTN       = 4,
    parameter int unsigned DEB_CYCLES  = DEB_CYCLES_BOARD,
    parameter int unsigned LONG_CYCLES = LONG_CYCLES_BOARD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_rise,
    output logic [N_BTN-1:0] btn_fall,
    output logic [N_BTN-1:0] btn_long
);

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        debounce_channel #(
            .DEB_CYCLES (DEB_CYCLES),
            .LONG_CYCLES(LONG_CYCLES)
        ) u_ch (
            .clk_i  (clk),
            .rst_ni (rst),
            .pin_i  (btn_in[g]),
            .level_o(btn_level[g]),
            .rise_o (btn_rise[g]),
            .fall_o (btn_fall[g]),
            .long_o (btn_long[g])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with shortened debounce/long timing.
module tb_button_conditioner;
    import button_conditioner_pkg::*;

    localparam int unsigned N    = 4;
    localparam int unsigned DEB  = DEB_CYCLES_SIM;
    localparam int unsigned LONG = LONG_CYCLES_SIM;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn_in;
    logic [N-1:0] btn_level, btn_rise, btn_fall, btn_long;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    button_conditioner #(
        .N_BTN      (N),
        .DEB_CYCLES (DEB),
        .LONG_CYCLES(LONG)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (btn_in),
        .btn_level(btn_level),
        .btn_rise (btn_rise),
        .btn_fall (btn_fall),
        .btn_long (btn_long)
    );

    // Window record: pin pattern held for a number of cycles, then the level at
    // the end and the set of channels expected to pulse once inside the window.
    typedef struct {
        string       name;
        logic [3:0]  pin;
        int unsigned cycles;
        logic [3:0]  level;
        logic [3:0]  rise;
        logic [3:0]  fall;
        logic [3:0]  lng;
    } vec_t;

    // Exact-timing record: full output word {level,rise,fall,long} at sample j.
    typedef struct {
        string       name;
        int unsigned at;
        logic [15:0] outs;
    } tick_t;

    vec_t  vecs[$];
    vec_t  sb[$];
    tick_t tq[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add_vec(input string name, input logic [3:0] pin, input int unsigned cycles,
                                    input logic [3:0] level, input logic [3:0] rise,
                                    input logic [3:0] fall, input logic [3:0] lng);
        vec_t v;
        v.name = name; v.pin = pin; v.cycles = cycles;
        v.level = level; v.rise = rise; v.fall = fall; v.lng = lng;
        vecs.push_back(v);
    endfunction

    function automatic void add_tick(input string name, input int unsigned at, input logic [3:0] level,
                                     input logic [3:0] rise, input logic [3:0] fall, input logic [3:0] lng);
        tick_t t;
        t.name = name; t.at = at; t.outs = {level, rise, fall, lng};
        tq.push_back(t);
    endfunction

    // Entered just after a posedge; returns just after a posedge.
    task automatic run_vec(input vec_t v);
        vec_t       e;
        logic [3:0] r_seen, f_seen, l_seen, multi, overlap;
        sb.push_back(v);
        btn_in  = v.pin;
        r_seen  = '0; f_seen = '0; l_seen = '0; multi = '0; overlap = '0;
        for (int unsigned c = 0; c < v.cycles; c++) begin
            @(negedge clk);
            multi   |= (r_seen & btn_rise) | (f_seen & btn_fall) | (l_seen & btn_long);
            overlap |= (btn_rise & btn_fall) | (btn_long & btn_fall);
            r_seen  |= btn_rise;
            f_seen  |= btn_fall;
            l_seen  |= btn_long;
        end
        e = sb.pop_front();
        check({e.name, "/level"},   16'(btn_level), 16'(e.level));
        check({e.name, "/rise"},    16'(r_seen),    16'(e.rise));
        check({e.name, "/fall"},    16'(f_seen),    16'(e.fall));
        check({e.name, "/long"},    16'(l_seen),    16'(e.lng));
        check({e.name, "/repeat"},  16'(multi),     16'h0);
        check({e.name, "/overlap"}, 16'(overlap),   16'h0);
        @(posedge clk); #1;
    endtask

    // Drives pin, then compares pending ticks at their sample index.
    task automatic run_timed(input logic [3:0] pin, input int unsigned cycles);
        tick_t t;
        btn_in = pin;
        for (int unsigned j = 0; j < cycles; j++) begin
            @(negedge clk);
            while (tq.size() > 0 && tq[0].at == j) begin
                t = tq.pop_front();
                check(t.name, {btn_level, btn_rise, btn_fall, btn_long}, t.outs);
            end
        end
        check("tick_queue_drained", 16'(tq.size()), 16'h0);
        tq.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst    = 1'b0;
        btn_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", {btn_level, btn_rise, btn_fall, btn_long}, 16'h0);
        @(posedge clk); #1;
        rst = 1'b1;

        //       name           pin      cyc  level    rise     fall     long
        add_vec("idle",        4'b0000,  8, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add_vec("clean_press", 4'b0001, 10, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        add_vec("clean_rel",   4'b0000, 10, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        add_vec("glitch",      4'b0010,  3, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add_vec("glitch_rel",  4'b0000, 10, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add_vec("min_press",   4'b1000,  4, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add_vec("min_rel",     4'b0000, 10, 4'b0000, 4'b1000, 4'b1000, 4'b0000);
        add_vec("long_hold",   4'b0100, 40, 4'b0100, 4'b0100, 4'b0000, 4'b0100);
        add_vec("long_rel",    4'b0000, 10, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
        add_vec("bounce_hold", 4'b0001, 30, 4'b0001, 4'b0001, 4'b0000, 4'b0001);
        add_vec("bounce_drop", 4'b0000,  2, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        add_vec("bounce_back", 4'b0001, 20, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        add_vec("bounce_rel",  4'b0000, 10, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        add_vec("all_press",   4'b1111, 10, 4'b1111, 4'b1111, 4'b0000, 4'b0000);
        add_vec("all_rel",     4'b0000, 10, 4'b0000, 4'b0000, 4'b1111, 4'b0000);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Sample j sees the outputs after edge j-1; pulses are due after edge DEB+2.
        add_tick("press_j6", DEB + 2, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add_tick("press_j7", DEB + 3, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        add_tick("press_j8", DEB + 4, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        run_timed(4'b0001, 10);
        add_tick("release_j6", DEB + 2, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        add_tick("release_j7", DEB + 3, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        add_tick("release_j8", DEB + 4, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        run_timed(4'b0000, 10);

        add_tick("long_rise",  DEB + 3,          4'b0100, 4'b0100, 4'b0000, 4'b0000);
        add_tick("long_pre",   DEB + 3 + LONG - 2, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        add_tick("long_pulse", DEB + 3 + LONG - 1, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
        add_tick("long_post",  DEB + 3 + LONG,     4'b0100, 4'b0000, 4'b0000, 4'b0000);
        run_timed(4'b0100, 30);
        add_tick("long_fall",  DEB + 3, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
        run_timed(4'b0000, 10);

        add_tick("all_rise", DEB + 3, 4'b1111, 4'b1111, 4'b0000, 4'b0000);
        run_timed(4'b1111, 10);
        #2;
        rst = 1'b0;
        #1;
        check("reset_async", {btn_level, btn_rise, btn_fall, btn_long}, 16'h0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        add_tick("rerise_j6", DEB + 2, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add_tick("rerise_j7", DEB + 3, 4'b1111, 4'b1111, 4'b0000, 4'b0000);
        add_tick("rerise_j8", DEB + 4, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        run_timed(4'b1111, 10);
        add_tick("refall", DEB + 3, 4'b0000, 4'b0000, 4'b1111, 4'b0000);
        run_timed(4'b0000, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
